pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_VEC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-stack entries; legal values 2..8.
REQ-003 SHALL have port i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rstN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_cond  in  1  jump condition from the jump-condition evaluator, valid in EXEC.
REQ-006 SHALL have port i_isJump  in  1  decoded instruction is a conditional jump.
REQ-007 SHALL have port i_isCall  in  1  decoded instruction is a call (unconditional).
REQ-008 SHALL have port i_isRet  in  1  decoded instruction is a return.
REQ-009 SHALL have port i_jTarget  in  16  jump/call target address.
REQ-010 SHALL have port i_imemAck  in  1  instruction memory has returned the word at o_pc.
REQ-011 SHALL have port i_stall  in  1  hold EXEC, no PC update.
REQ-012 SHALL have port o_pc  out  16  current program counter.
REQ-013 SHALL have port o_fetchReq  out  1  fetch request for address o_pc.
REQ-014 SHALL have port o_flush  out  1  one-cycle squash of the younger instruction after a taken redirect.
REQ-015 SHALL have port o_stackErr  out  1  one-cycle pulse on return-stack overflow/underflow.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, EXEC; IDLE->FETCH unconditionally after one cycle.
REQ-017 In FETCH, o_fetchReq SHALL be 1; o_pc held; FETCH->EXEC on i_imemAck=1; i_stall ignored in FETCH.
REQ-018 In EXEC with i_stall=1, SHALL hold state and o_pc, o_flush=0, no stack change.
REQ-019 In EXEC with i_stall=0, SHALL update o_pc on that edge and return to FETCH; latency ack-to-new-PC = 2 edges.
REQ-020 Priority SHALL be i_isRet > i_isCall > i_isJump > sequential.
REQ-021 Taken jump (i_isJump & i_cond): o_pc<=i_jTarget, o_flush=1 for the following cycle.
REQ-022 Not-taken jump or no control op: o_pc<=o_pc+1, modulo 2^16 (16'hFFFF wraps to 16'h0000), o_flush=0.
REQ-023 Call: push o_pc+1 (wrapped), o_pc<=i_jTarget, o_flush=1 regardless of i_cond.
REQ-024 Return: pop into o_pc, o_flush=1.
REQ-025 Push when full SHALL not modify stack, still redirect, pulse o_stackErr.
REQ-026 Pop when empty SHALL leave o_pc<=o_pc+1, o_flush=0, pulse o_stackErr.

Reset
REQ-027 On i_rstN=0, immediately: state=IDLE, o_pc=RESET_VEC, o_fetchReq=0, o_flush=0, o_stackErr=0, stack emptied.
REQ-028 Reset asserted mid-FETCH or mid-EXEC SHALL abort the operation with no pending push/pop retained.

Configuration
REQ-029 Macro PC_CALL_STACK_EN SHALL compile in the return stack and REQ-023..026.
REQ-030 Without PC_CALL_STACK_EN, i_isCall/i_isRet SHALL be ignored (treated as sequential), o_stackErr tied 0, no stack storage.

Structure
REQ-031 Shared package pc_pkg SHALL hold the FSM state enum, PC width constant (16) and default RESET_VEC.
REQ-032 Return stack SHALL be a sub-module ret_stack (push/pop/full/empty, depth STACK_DEPTH).

Verification
REQ-033 Reset release, ack every FETCH -> o_pc sequence 0x0000,0x0001,0x0002; o_fetchReq low in IDLE only.
REQ-034 o_pc=0x0010, i_isJump=1, i_cond=1, i_jTarget=0x0200 -> o_pc=0x0200, o_flush=1 one cycle; i_cond=0 -> o_pc=0x0011, o_flush=0.
REQ-035 o_pc=0xFFFF sequential -> o_pc=0x0000.
REQ-036 i_stall=1 for 3 EXEC cycles then 0 -> o_pc unchanged for 3 cycles, single increment after.
REQ-037 With macro: call at 0x0040 to 0x0100, return -> o_pc=0x0041; five nested calls at depth 4 -> o_stackErr pulse on fifth; return on empty -> o_stackErr pulse, o_pc+1.
REQ-038 Reset asserted in EXEC during call -> o_pc=RESET_VEC, stack empty, next return yields o_stackErr.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter controller.
// PC_W is the address width; RESET_VEC_DEF seeds the reset vector.
package pc_pkg;

   localparam int PC_W = 16;
   localparam logic [PC_W-1:0] RESET_VEC_DEF = 16'h0000;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      EXEC
   } state_t;

endpackage

// File: rtl/pc_ctrl_ret_stack.sv
// LIFO of return addresses for the program-counter controller.
// Pushing when full and popping when empty leave the contents untouched.
module ret_stack
   import pc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] din,
   output logic [PC_W-1:0] dout,
   output logic            full,
   output logic            empty
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [PC_W-1:0] mem [DEPTH];
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   wr_idx;
   logic [AW-1:0]   top_idx;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign wr_idx  = AW'(cnt);
   assign top_idx = AW'(cnt - 1'b1);
   assign dout    = empty ? '0 : mem[top_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !full) begin
         mem[wr_idx] <= din;
         cnt         <= cnt + 1'b1;
      end else if (pop && !empty) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter sequencer: IDLE -> FETCH -> EXEC with jump/call/return.
// Build with PC_CALL_STACK_EN to enable call/return via the return stack.
module pc_ctrl
   import pc_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VEC   = RESET_VEC_DEF,
   parameter int              STACK_DEPTH = 4
) (
   input  logic            i_clk,
   input  logic            i_rstN,
   input  logic            i_cond,
   input  logic            i_isJump,
   input  logic            i_isCall,
   input  logic            i_isRet,
   input  logic [PC_W-1:0] i_jTarget,
   input  logic            i_imemAck,
   input  logic            i_stall,
   output logic [PC_W-1:0] o_pc,
   output logic            o_fetchReq,
   output logic            o_flush,
   output logic            o_stackErr
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pc_inc;
   logic            flush_q, flush_d;
   logic            err_q, err_d;
   logic            push, pop;
   logic            is_call, is_ret;
   logic            st_full, st_empty;
   logic [PC_W-1:0] st_top;

`ifdef PC_CALL_STACK_EN
   assign is_call = i_isCall;
   assign is_ret  = i_isRet;

   ret_stack #(
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (i_clk),
      .rst_n (i_rstN),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .dout  (st_top),
      .full  (st_full),
      .empty (st_empty)
   );
`else
   logic unused_ok;

   assign is_call   = 1'b0;
   assign is_ret    = 1'b0;
   assign st_full   = 1'b0;
   assign st_empty  = 1'b1;
   assign st_top    = '0;
   assign unused_ok = ^{i_isCall, i_isRet, push, pop};
`endif

   assign pc_inc     = pc_q + 16'd1;
   assign o_pc       = pc_q;
   assign o_fetchReq = (state_q == FETCH);
   assign o_flush    = flush_q;
   assign o_stackErr = err_q;

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         state_q <= IDLE;
         pc_q    <= RESET_VEC;
         flush_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flush_q <= flush_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush_d = 1'b0;
      err_d   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (i_imemAck) state_d = EXEC;
         end
         EXEC: begin
            if (!i_stall) begin
               state_d = FETCH;
               if (is_ret) begin
                  // Underflow falls through as a plain sequential step
                  if (st_empty) begin
                     pc_d  = pc_inc;
                     err_d = 1'b1;
                  end else begin
                     pc_d    = st_top;
                     flush_d = 1'b1;
                     pop     = 1'b1;
                  end
               end else if (is_call) begin
                  pc_d    = i_jTarget;
                  flush_d = 1'b1;
                  push    = !st_full;
                  err_d   = st_full;
               end else if (i_isJump && i_cond) begin
                  pc_d    = i_jTarget;
                  flush_d = 1'b1;
               end else begin
                  pc_d = pc_inc;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Randomized and directed bench for pc_ctrl against a queue-based model.
// Follows PC_CALL_STACK_EN to decide whether call/return are modelled.
module tb_pc_ctrl;

   localparam logic [15:0] RV    = 16'h0000;
   localparam int          DEPTH = 4;
`ifdef PC_CALL_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cond, is_jump, is_call, is_ret, ack, stall;
   logic [15:0] tgt;
   logic [15:0] pc;
   logic        fetch_req, flush, stack_err;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] m_pc;
   logic [15:0] m_stk[$];

   always #5 clk = ~clk;

   pc_ctrl #(
      .RESET_VEC   (RV),
      .STACK_DEPTH (DEPTH)
   ) dut (
      .i_clk      (clk),
      .i_rstN     (rst_n),
      .i_cond     (cond),
      .i_isJump   (is_jump),
      .i_isCall   (is_call),
      .i_isRet    (is_ret),
      .i_jTarget  (tgt),
      .i_imemAck  (ack),
      .i_stall    (stall),
      .o_pc       (pc),
      .o_fetchReq (fetch_req),
      .o_flush    (flush),
      .o_stackErr (stack_err)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic clear_in();
      cond    = 1'b0;
      is_jump = 1'b0;
      is_call = 1'b0;
      is_ret  = 1'b0;
      ack     = 1'b0;
      stall   = 1'b0;
      tgt     = 16'h0000;
   endtask

   // Spec-level effect of one executed instruction on pc and stack
   task automatic model(input bit j, input bit c, input bit ca, input bit r,
                        input logic [15:0] t, output bit f, output bit e);
      f = 1'b0;
      e = 1'b0;
      if (STK && r) begin
         if (m_stk.size() == 0) begin
            e    = 1'b1;
            m_pc = m_pc + 16'd1;
         end else begin
            m_pc = m_stk.pop_back();
            f    = 1'b1;
         end
      end else if (STK && ca) begin
         if (m_stk.size() == DEPTH) e = 1'b1;
         else m_stk.push_back(m_pc + 16'd1);
         m_pc = t;
         f    = 1'b1;
      end else if (j && c) begin
         m_pc = t;
         f    = 1'b1;
      end else begin
         m_pc = m_pc + 16'd1;
      end
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 1'b0;
      m_pc  = RV;
      m_stk.delete();
      #1;
      check("rst_pc", pc, RV);
      check("rst_req", fetch_req, 0);
      check("rst_flush", flush, 0);
      check("rst_err", stack_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("idle_req", fetch_req, 0);
      @(negedge clk);
      check("fetch_req", fetch_req, 1);
      check("fetch_pc", pc, m_pc);
   endtask

   // Called at a negedge in FETCH; returns at a negedge in EXEC
   task automatic fetch(input int wait_n);
      for (int i = 0; i < wait_n; i++) begin
         ack = 1'b0;
         @(negedge clk);
         check("wait_req", fetch_req, 1);
         check("wait_pc", pc, m_pc);
         check("wait_flush", flush, 0);
         check("wait_err", stack_err, 0);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic exec(input bit j, input bit c, input bit ca, input bit r,
                       input logic [15:0] t, input int stalls);
      bit f, e;
      is_jump = j;
      cond    = c;
      is_call = ca;
      is_ret  = r;
      tgt     = t;
      stall   = 1'b1;
      for (int i = 0; i < stalls; i++) begin
         @(negedge clk);
         check("stall_pc", pc, m_pc);
         check("stall_flush", flush, 0);
         check("stall_err", stack_err, 0);
      end
      stall = 1'b0;
      model(j, c, ca, r, t, f, e);
      @(negedge clk);
      clear_in();
      check("exec_pc", pc, m_pc);
      check("exec_flush", flush, f);
      check("exec_err", stack_err, e);
      check("exec_req", fetch_req, 1);
   endtask

   task automatic go(input bit j, input bit c, input bit ca, input bit r,
                     input logic [15:0] t);
      fetch(0);
      exec(j, c, ca, r, t, 0);
   endtask

   initial begin
      #100000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_in();
      #2;
      do_reset();
      go(0, 0, 0, 0, 16'h0);
      fetch(1);
      exec(0, 0, 0, 0, 16'h0, 0);

      go(1, 1, 0, 0, 16'h0010);
      go(1, 1, 0, 0, 16'h0200);
      go(1, 1, 0, 0, 16'h0010);
      go(1, 0, 0, 0, 16'h0200);

      go(1, 1, 0, 0, 16'hFFFF);
      go(0, 0, 0, 0, 16'h1234);

      fetch(0);
      exec(0, 0, 0, 0, 16'h0, 3);

      go(1, 1, 0, 0, 16'h0040);
      go(0, 0, 1, 0, 16'h0100);
      go(0, 0, 0, 1, 16'h0);
      for (int i = 0; i < 5; i++) go(0, 0, 1, 0, 16'h0300 + 16'(i));
      for (int i = 0; i < 5; i++) go(0, 0, 0, 1, 16'h0);

      go(0, 0, 1, 0, 16'h0500);
      go(0, 0, 1, 0, 16'h0600);
      fetch(0);
      is_call = 1'b1;
      tgt     = 16'h0700;
      do_reset();
      go(0, 0, 0, 1, 16'h0);

      for (int n = 0; n < 300; n++) begin
         int          op;
         logic [15:0] t;
         op = $urandom_range(0, 9);
         t  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         fetch($urandom_range(0, 2));
         exec(op >= 4 && op <= 6, 1'($urandom), op == 2 || op == 3,
              op <= 1, t, $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
